// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, FSM state types and counter sizing for the UART command link
package uart_pkg;
  localparam logic [7:0] RESP_COMPLETE     = 8'hA5;
  localparam logic [7:0] RESP_INTERMEDIATE = 8'h5A;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;
  typedef enum logic {WAIT_HI, WAIT_LO} cmd_state_t;
  function automatic int cnt_w(input int div);
    return ($clog2(div) + 1 > 12) ? $clog2(div) + 1 : 12;
  endfunction
endpackage

// File: rtl/uart_cmd_responder_if.sv
// uart_cmd_responder_if: command/response handshake between the UART responder and the command processor
interface uart_cmd_responder_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;
  logic        tx_busy;
  modport master (input cmd, cmd_rdy, resp_sent, tx_busy, output clr_cmd_rdy, resp, send_resp);
  modport slave (output cmd, cmd_rdy, resp_sent, tx_busy, input clr_cmd_rdy, resp, send_resp);
endinterface

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 byte receiver with RX synchroniser, false-start rejection and stop-bit check
module uart_byte_rx import uart_pkg::*; #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic [7:0] rx_byte,
  output logic       rx_byte_vld
);
  localparam int W = cnt_w(BAUD_DIV);
  logic [2:0]   sync;
  rx_state_t    st, st_nxt;
  logic [W-1:0] cnt, cnt_nxt;
  logic [3:0]   bit_cnt, bit_nxt;
  logic [7:0]   sh, sh_nxt;
  logic         vld_nxt;
  logic         rx_s, falling, tick;
  assign rx_s    = sync[1];
  assign falling = sync[2] & ~sync[1];
  assign tick    = cnt == '0;
  assign rx_byte = sh;
  // two-flop synchroniser plus one history flop for edge detection, all preset to idle-high
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '1;
    else sync <= {sync[1:0], RX};
  // receiver state, baud/bit counters and shift register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st          <= RX_IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      sh          <= '0;
      rx_byte_vld <= 1'b0;
    end else begin
      st          <= st_nxt;
      cnt         <= cnt_nxt;
      bit_cnt     <= bit_nxt;
      sh          <= sh_nxt;
      rx_byte_vld <= vld_nxt;
    end
  // frame sequencing: half-bit to start-bit centre, then one bit period per sample
  always_comb begin
    st_nxt  = st;
    cnt_nxt = tick ? W'(BAUD_DIV - 1) : cnt - 1'b1;
    bit_nxt = bit_cnt;
    sh_nxt  = sh;
    vld_nxt = 1'b0;
    case (st)
      RX_IDLE: begin
        bit_nxt = '0;
        cnt_nxt = W'(BAUD_DIV / 2);
        st_nxt  = falling ? RX_START : RX_IDLE;
      end
      RX_START: if (tick) begin
        st_nxt  = rx_s ? RX_IDLE : RX_DATA;
        bit_nxt = 4'd1;
      end
      RX_DATA: if (tick) begin
        sh_nxt  = {rx_s, sh[7:1]};
        bit_nxt = bit_cnt + 1'b1;
        st_nxt  = (bit_cnt == 4'd8) ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (tick) begin
        vld_nxt = rx_s;
        st_nxt  = RX_IDLE;
      end
      default: st_nxt = RX_IDLE;
    endcase
  end
endmodule

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: receives 2-byte commands and transmits 1-byte responses over 8N1 UART; CMD_TIMEOUT_EN adds a high/low byte timeout
module uart_cmd_responder import uart_pkg::*; #(
  parameter int BAUD_DIV     = 2604,
  parameter int TIMEOUT_CLKS = 2500000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX,
  output logic                 TX,
  uart_cmd_responder_if.slave  bus
);
  localparam int W = cnt_w(BAUD_DIV);
  if (BAUD_DIV < 16 || TIMEOUT_CLKS < 1) begin : g_bad_cfg
    $error("uart_cmd_responder: BAUD_DIV must be >= 16 and TIMEOUT_CLKS >= 1");
  end
  logic [7:0]   rx_byte;
  logic         rx_byte_vld;
  cmd_state_t   cs, cs_nxt;
  logic [7:0]   hi;
  logic         tmo;
  tx_state_t    ts, ts_nxt;
  logic [9:0]   tsh, tsh_nxt;
  logic [W-1:0] tcnt, tcnt_nxt;
  logic [3:0]   tbit, tbit_nxt;
  logic         sent_nxt;
  uart_byte_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .rx_byte     (rx_byte),
    .rx_byte_vld (rx_byte_vld)
  );
`ifdef CMD_TIMEOUT_EN
  logic [21:0] tmo_cnt;
  assign tmo = tmo_cnt == 22'(TIMEOUT_CLKS);
  // clocks spent waiting for the low byte, restarted on every entry to WAIT_LO
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tmo_cnt <= '0;
    else tmo_cnt <= (cs == WAIT_LO && cs_nxt == WAIT_LO) ? tmo_cnt + 1'b1 : '0;
`else
  assign tmo = 1'b0;
`endif
  // command assembly state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cs <= WAIT_HI;
    else cs <= cs_nxt;
  // each received byte alternates high/low; a timeout abandons a lone high byte
  always_comb
    cs_nxt = rx_byte_vld ? (cs == WAIT_HI ? WAIT_LO : WAIT_HI) : (cs == WAIT_LO && tmo) ? WAIT_HI : cs;
  // high byte capture, cmd update on the low byte, cmd_rdy with set taking priority over clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hi          <= '0;
      bus.cmd     <= '0;
      bus.cmd_rdy <= 1'b0;
    end else begin
      hi <= (cs == WAIT_HI && rx_byte_vld) ? rx_byte : hi;
      if (cs == WAIT_LO && rx_byte_vld) begin
        bus.cmd     <= {hi, rx_byte};
        bus.cmd_rdy <= 1'b1;
      end else if ((cs == WAIT_HI && rx_byte_vld) || bus.clr_cmd_rdy) bus.cmd_rdy <= 1'b0;
    end
  assign TX          = tsh[0];
  assign bus.tx_busy = ts == TX_XMIT;
  // transmitter state, shifter and counters; the shifter idles all-ones so TX rests high
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ts            <= TX_IDLE;
      tsh           <= '1;
      tcnt          <= '0;
      tbit          <= '0;
      bus.resp_sent <= 1'b0;
    end else begin
      ts            <= ts_nxt;
      tsh           <= tsh_nxt;
      tcnt          <= tcnt_nxt;
      tbit          <= tbit_nxt;
      bus.resp_sent <= sent_nxt;
    end
  // frame {stop, data, start} shifted LSB first; the stop bit gets one extra clock so resp_sent lands at 10*BAUD_DIV+1
  always_comb begin
    ts_nxt   = ts;
    tsh_nxt  = tsh;
    tcnt_nxt = (ts == TX_XMIT) ? tcnt - 1'b1 : tcnt;
    tbit_nxt = tbit;
    sent_nxt = bus.resp_sent;
    if (ts == TX_IDLE) begin
      if (bus.send_resp) begin
        ts_nxt   = TX_XMIT;
        tsh_nxt  = {1'b1, bus.resp, 1'b0};
        tcnt_nxt = W'(BAUD_DIV - 1);
        tbit_nxt = '0;
        sent_nxt = 1'b0;
      end
    end else if (tcnt == '0) begin
      if (tbit == 4'd9) begin
        ts_nxt   = TX_IDLE;
        sent_nxt = 1'b1;
      end else begin
        tsh_nxt  = {1'b1, tsh[9:1]};
        tbit_nxt = tbit + 1'b1;
        tcnt_nxt = (tbit == 4'd8) ? W'(BAUD_DIV) : W'(BAUD_DIV - 1);
      end
    end
  end
endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb_uart_cmd_responder: directed bench with a command scoreboard and mid-bit TX checks at BAUD_DIV=16
module tb_uart_cmd_responder;
  import uart_pkg::*;
  localparam int BD = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic tx;
  int checks = 0;
  int failures = 0;
  logic [15:0] sb[$];
  logic [15:0] exp_cmd;
  logic prev_rdy = 1'b0;
  logic tx_q[$];
  logic [9:0] frame;
  logic exp_bit;
  uart_cmd_responder_if bus();
  uart_cmd_responder #(.BAUD_DIV(BD), .TIMEOUT_CLKS(500)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RX    (rx),
    .TX    (tx),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.cmd_rdy && !prev_rdy) begin
      exp_cmd = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
      chk("cmd_scoreboard", bus.cmd, exp_cmd);
    end
    prev_rdy = bus.cmd_rdy;
  end
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BD) @(negedge clk);
    end
    rx = stop;
    repeat (BD) @(negedge clk);
    rx = 1'b1;
  endtask
  task automatic clr_pulse();
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
  endtask
  initial begin
    bus.clr_cmd_rdy = 1'b0;
    bus.resp = 8'h00;
    bus.send_resp = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_cmd", bus.cmd, 16'h0000);
    chk("rst_cmd_rdy", bus.cmd_rdy, 1'b0);
    chk("rst_resp_sent", bus.resp_sent, 1'b0);
    chk("rst_tx_busy", bus.tx_busy, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_byte(8'h2F, 1'b1);
    sb.push_back(16'h2F45);
    send_byte(8'h45, 1'b1);
    @(negedge clk);
    chk("t1_sb_drain", sb.size(), 0);
    chk("t1_cmd_rdy", bus.cmd_rdy, 1'b1);
    clr_pulse();
    chk("t1_clr", bus.cmd_rdy, 1'b0);
    frame = {1'b1, RESP_COMPLETE, 1'b0};
    for (int i = 0; i < 10; i++) tx_q.push_back(frame[i]);
    bus.resp = RESP_COMPLETE;
    bus.send_resp = 1'b1;
    for (int k = 1; k <= 162; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.send_resp = 1'b0;
        chk("t2_busy_start", bus.tx_busy, 1'b1);
      end
      if (k == 40) begin
        bus.resp = RESP_INTERMEDIATE;
        bus.send_resp = 1'b1;
      end
      if (k == 41) bus.send_resp = 1'b0;
      if (k >= 9 && k <= 153 && (k - 9) % BD == 0) begin
        exp_bit = tx_q.pop_front();
        chk("t2_tx_bit", tx, exp_bit);
      end
      if (k == 161) begin
        chk("t2_sent_early", bus.resp_sent, 1'b0);
        chk("t2_busy_late", bus.tx_busy, 1'b1);
      end
      if (k == 162) begin
        chk("t2_resp_sent", bus.resp_sent, 1'b1);
        chk("t2_busy_end", bus.tx_busy, 1'b0);
      end
    end
    repeat (BD * 4) @(negedge clk);
    chk("t2_second_ignored", bus.tx_busy, 1'b0);
    chk("t2_tx_idle", tx, 1'b1);
    sb.push_back(16'h0000);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    chk("t3_sb_drain", sb.size(), 0);
    chk("t3_hi_clears_rdy", bus.cmd_rdy, 1'b0);
    chk("t3_cmd_hold", bus.cmd, 16'h0000);
    sb.push_back(16'hFFFF);
    send_byte(8'hFF, 1'b1);
    @(negedge clk);
    chk("t3_sb_drain2", sb.size(), 0);
    chk("t3_cmd_rdy", bus.cmd_rdy, 1'b1);
    clr_pulse();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("t4_glitch_rdy", bus.cmd_rdy, 1'b0);
    send_byte(8'h11, 1'b1);
    send_byte(8'h99, 1'b0);
    repeat (20) @(negedge clk);
    chk("t4_badstop_rdy", bus.cmd_rdy, 1'b0);
    chk("t4_badstop_cmd", bus.cmd, 16'hFFFF);
    sb.push_back(16'h1122);
    send_byte(8'h22, 1'b1);
    @(negedge clk);
    chk("t4_sb_drain", sb.size(), 0);
    chk("t4_cmd_rdy", bus.cmd_rdy, 1'b1);
    send_byte(8'hAB, 1'b1);
    bus.resp = 8'h00;
    bus.send_resp = 1'b1;
    @(negedge clk);
    bus.send_resp = 1'b0;
    rx = 1'b0;
    repeat (BD) @(negedge clk);
    rx = 1'b1;
    repeat (BD * 3) @(negedge clk);
    chk("t5_pre_busy", bus.tx_busy, 1'b1);
    chk("t5_pre_tx", tx, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_tx", tx, 1'b1);
    chk("t5_rst_rdy", bus.cmd_rdy, 1'b0);
    chk("t5_rst_busy", bus.tx_busy, 1'b0);
    chk("t5_rst_cmd", bus.cmd, 16'h0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_resp_sent", bus.resp_sent, 1'b0);
    sb.push_back(16'hABCD);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    @(negedge clk);
    chk("t5_sb_drain", sb.size(), 0);
`ifdef CMD_TIMEOUT_EN
    clr_pulse();
    send_byte(8'h77, 1'b1);
    repeat (600) @(negedge clk);
    chk("t6_no_rdy", bus.cmd_rdy, 1'b0);
    sb.push_back(16'h1234);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    @(negedge clk);
    chk("t6_sb_drain", sb.size(), 0);
    chk("t6_cmd", bus.cmd, 16'h1234);
`endif
    repeat (5) @(negedge clk);
    chk("sb_final", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
